hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Parametrised HI/LO register unit with integrated multiply and iterative divide, sitting beside the ALU in the execute stage. It holds the architectural HI and LO registers and accepts MTHI/MTLO writes. It executes MULT/MULTU in a one-stage pipeline and DIV/DIVU as a W-iteration sequential divider, with results committed to HI/LO. The pipeline stalls on `busy` and reads HI/LO through a bypassed read port.

## Interface
- `W`, 32, operand / HI / LO width (≥ 4)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  operation request
- `op`  in  3  0=MTHI, 1=MTLO, 2=MULT, 3=MULTU, 4=DIV, 5=DIVU, 6/7 ignored (accepted, no effect)
- `src_a`  in  W  MT data / multiplicand / dividend
- `src_b`  in  W  multiplier / divisor
- `flush`  in  1  abandon in-flight operation (exception / branch kill)
- `op_ready`  out  1  = !busy && !flush; op accepted when `op_valid && op_ready`
- `busy`  out  1  mult/div in flight
- `done`  out  1  one-cycle pulse: mult/div result just committed
- `rd_sel`  in  1  0=read LO, 1=read HI
- `rd_data`  out  W  HI/LO read data, combinational, bypassed

## Operation
- Reset (`rst`=0, async): HI=LO=0, `busy`=0, `done`=0, divider state cleared; `rd_data`=0.
- MTHI/MTLO: on accept, HI (or LO) <= `src_a` at that edge; other register unchanged.
- Read bypass: in the cycle an MTHI (MTLO) is accepted, `rd_data` with `rd_sel`=1 (0) returns `src_a`; otherwise it returns the register.
- MULT/MULTU: {HI,LO} <= 2W-bit product of signed/unsigned operands.
- DIV/DIVU: LO=quotient, HI=remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed divide uses magnitudes and restoring division, one quotient bit per cycle, MSB first, followed by one sign-fix cycle.
- Divide by zero (both modes): LO = all ones, HI = `src_a`.
- DIV of -2^(W-1) by -1: LO = -2^(W-1) (wraps), HI = 0.
- Operands are latched on accept; `src_a`/`src_b` may change afterwards.
- States: IDLE, MUL (1 cycle), DIV_ITER (W cycles), DIV_FIX (1 cycle), then back to IDLE with `done`.
- `flush`=1: any state → IDLE at the next edge, HI/LO untouched, no `done`. An op presented in the same cycle is not accepted, MT included.
- Opcodes 6/7: accepted, no state change, no `done`.

## Timing
- Accept at the edge ending cycle N.
- MT: new value visible in cycle N+1; bypass visible in cycle N.
- MULT: `busy`=1 in cycle N+1; HI/LO updated at the end of N+1; `done`=1 and `busy`=0 in N+2.
- DIV: `busy`=1 in cycles N+1..N+W+1 (W iterations + fix); HI/LO updated at the end of N+W+1; `done`=1 in N+W+2.
- `done` coincides with `op_ready`=1, so back-to-back ops lose no cycle.
- Flush in cycle K while busy: `busy`=0 in K+1; HI/LO hold pre-op values.
- Reset asserted mid-divide: immediate return to reset values; no `done` after release.

## Test plan
- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 in consecutive cycles: `rd_data` returns each value in its accept cycle (bypass) and afterwards.
- MULT 0xFFFFFFFF × 0x00000002: HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands: HI=0x00000001, LO=0xFFFFFFFE. Both give `done` at N+2.
- DIV -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7: LO=14, HI=2. `busy` high exactly 33 cycles, `done` at N+34.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. DIVU 5 / 0 gives LO=0xFFFFFFFF, HI=5.
- Start DIV, assert `flush` at iteration 10 while `op_valid` carries MTHI: `busy` drops the next cycle, no `done`, HI/LO unchanged, MTHI not applied.
- Assert `rst`=0 mid-DIV for a partial cycle (async): HI=LO=0 and `busy`=0 immediately; MULT issued on the `done` cycle of a prior DIV is accepted and completes two cycles later.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO register unit with one-cycle multiply and restoring divide
module hilo_muldiv_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    input  logic [2:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         flush,
    output logic         op_ready,
    output logic         busy,
    output logic         done,
    input  logic         rd_sel,
    output logic [W-1:0] rd_data
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIX} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  q_q, q_d, r_q, r_d, d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
    logic          done_q, done_d;

    logic          accept;
    logic          div_signed;
    logic [W-1:0]  abs_a, abs_b;
    logic [2*W-1:0] ext_a, ext_b, prod;
    logic [W:0]    rem_sh, diff;

    assign busy     = (state_q != S_IDLE);
    assign op_ready = !busy && !flush;
    assign done     = done_q;
    assign accept   = op_valid && op_ready;

    // Bypass is gated by reset so rd_data reads zero while rst is low.
    always_comb begin
        rd_data = rd_sel ? hi_q : lo_q;
        if (accept && rst) begin
            if (op == 3'd0 && rd_sel)  rd_data = src_a;
            if (op == 3'd1 && !rd_sel) rd_data = src_a;
        end
    end

    always_comb begin
        div_signed = (op == 3'd4);
        abs_a = (div_signed && src_a[W-1]) ? -src_a : src_a;
        abs_b = (div_signed && src_b[W-1]) ? -src_b : src_b;
        ext_a = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
        ext_b = sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
        prod  = ext_a * ext_b;
        rem_sh = {r_q, q_q[W-1]};
        diff   = rem_sh - {1'b0, d_q};
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        3'd0: hi_d = src_a;
                        3'd1: lo_d = src_a;
                        3'd2, 3'd3: begin
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = (op == 3'd2);
                            state_d = S_MUL;
                        end
                        3'd4, 3'd5: begin
                            a_d     = src_a;
                            q_d     = abs_a;
                            d_d     = abs_b;
                            r_d     = '0;
                            cnt_d   = CW'(W - 1);
                            negq_d  = div_signed && (src_a[W-1] ^ src_b[W-1]);
                            negr_d  = div_signed && src_a[W-1];
                            dz_d    = (src_b == '0);
                            state_d = S_DIV_ITER;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                {hi_d, lo_d} = prod;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_DIV_ITER: begin
                // Restoring step: keep the trial subtraction only when it does not borrow.
                if (!diff[W]) begin
                    r_d = diff[W-1:0];
                    q_d = {q_q[W-2:0], 1'b1};
                end else begin
                    r_d = rem_sh[W-1:0];
                    q_d = {q_q[W-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = S_DIV_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DIV_FIX: begin
                if (dz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = negq_q ? -q_q : q_q;
                    hi_d = negr_q ? -r_q : r_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        op_ready, busy, done;
    logic        rd_sel;
    logic [31:0] rd_data;

    int tests = 0;
    int fails = 0;

    hilo_muldiv_unit #(.W(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .op_ready(op_ready), .busy(busy), .done(done),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        rd_sel = 1'b1; #1;
        chk({tag, "_hi"}, rd_data, exp_hi);
        rd_sel = 1'b0; #1;
        chk({tag, "_lo"}, rd_data, exp_lo);
    endtask

    task automatic do_mul(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        next();
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        next();
        op_valid = 1'b0; src_a = 32'h5A5A5A5A; src_b = 32'hA5A5A5A5;
        chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done1"}, {31'd0, done}, 32'd0);
        next();
        chk({tag, "_done2"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy2"}, {31'd0, busy}, 32'd0);
        rd_chk(tag, ehi, elo);
    endtask

    task automatic do_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int bc;
        int dc;
        bc = 0; dc = 0;
        next();
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        next();
        op_valid = 1'b0; src_a = 32'h13579BDF; src_b = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) next();
            if (busy) bc++;
            if (done && dc == 0) dc = i;
        end
        chk({tag, "_busycnt"}, bc, 32'd33);
        chk({tag, "_donecyc"}, dc, 32'd34);
        rd_chk(tag, ehi, elo);
    endtask

    initial begin
        int dc;
        rst = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        flush = 1'b0; rd_sel = 1'b0;
        next(); next();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, op_ready}, 32'd1);
        rd_chk("rst", 32'd0, 32'd0);
        next();
        rst = 1'b1;

        // MTHI then MTLO back to back, with bypass
        next();
        op_valid = 1'b1; op = 3'd0; src_a = 32'h12345678;
        rd_chk("mthi_byp", 32'h12345678, 32'd0);
        next();
        op = 3'd1; src_a = 32'h9ABCDEF0;
        rd_chk("mtlo_byp", 32'h12345678, 32'h9ABCDEF0);
        next();
        op_valid = 1'b0;
        rd_chk("mt_after", 32'h12345678, 32'h9ABCDEF0);

        do_mul("mult", 3'd2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_mul("multu", 3'd3, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE);

        do_div("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_div("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd2, 32'd14);
        do_div("div_7_m2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        do_div("div_min_m1", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        do_div("divu_5_0", 3'd5, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        do_div("div_m5_0", 3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Opcode 6 is accepted with no effect
        next();
        op_valid = 1'b1; op = 3'd6; src_a = 32'h11111111;
        chk("op6_ready", {31'd0, op_ready}, 32'd1);
        next();
        op_valid = 1'b0;
        chk("op6_busy", {31'd0, busy}, 32'd0);
        next();
        chk("op6_done", {31'd0, done}, 32'd0);
        rd_chk("op6", 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Flush at iteration 10 with an MTHI presented alongside
        next();
        op_valid = 1'b1; op = 3'd4; src_a = 32'd1000; src_b = 32'd3;
        next();
        op_valid = 1'b0;
        for (int i = 2; i <= 10; i++) next();
        flush = 1'b1; op_valid = 1'b1; op = 3'd0; src_a = 32'hDEADBEEF; rd_sel = 1'b1;
        #1;
        chk("flush_ready", {31'd0, op_ready}, 32'd0);
        chk("flush_nobyp", rd_data, 32'hFFFFFFFB);
        next();
        flush = 1'b0; op_valid = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dc++;
            next();
        end
        chk("flush_nodone", dc, 32'd0);
        rd_chk("flush", 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Asynchronous reset in the middle of a divide
        op_valid = 1'b1; op = 3'd5; src_a = 32'd100; src_b = 32'd7;
        next();
        op_valid = 1'b0;
        for (int i = 0; i < 5; i++) next();
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        rd_chk("arst", 32'd0, 32'd0);
        next();
        rst = 1'b1;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dc++;
            next();
        end
        chk("arst_nodone", dc, 32'd0);

        // MULT issued on the done cycle of a DIVU
        op_valid = 1'b1; op = 3'd5; src_a = 32'd100; src_b = 32'd7;
        next();
        op_valid = 1'b0;
        dc = 0;
        for (int i = 1; i <= 40 && dc == 0; i++) begin
            if (done) dc = i;
            else next();
        end
        chk("b2b_divdone", dc, 32'd34);
        chk("b2b_ready", {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1; op = 3'd2; src_a = 32'd3; src_b = 32'd5;
        rd_chk("b2b_div", 32'd2, 32'd14);
        next();
        op_valid = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        next();
        chk("b2b_done", {31'd0, done}, 32'd1);
        rd_chk("b2b_mul", 32'd0, 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
